fc_stream_engine: RTL and testbench
===================================

// Module: fc_stream_engine
// PURPOSE
//  Sequential, parametrised fully-connected layer: y[j] = sat(sum_k x[k]*W[k][j] >>> FRAC_W + b[j]), optional ReLU.
//  Input vector streamed one element per beat; all OUT_SIZE outputs accumulated in parallel, then drained one per beat.
//  Weights/biases held in internal registers loaded through a write port. Sits between activation stream producer and next layer.
// PARAMETERS
//  DATA_W   16  signed fixed-point width of x, W, b, y
//  FRAC_W    8  fractional bits (Q(DATA_W-FRAC_W).FRAC_W); product realigned by >>> FRAC_W
//  IN_SIZE   3  features per input vector (>=1)
//  OUT_SIZE  2  outputs per vector (>=1)
//  localparam ACC_W = 2*DATA_W + $clog2(IN_SIZE) + 1; IW = max(1,$clog2(IN_SIZE)); OW = max(1,$clog2(OUT_SIZE))
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  cfg_relu   in   1       1 = clamp negative results to 0
//  w_we       in   1       weight write strobe
//  w_row      in   IW      feature index k
//  w_col      in   OW      output index j
//  w_data     in   DATA_W  W[k][j]
//  b_we       in   1       bias write strobe
//  b_idx      in   OW      output index j
//  b_data     in   DATA_W  b[j]
//  in_valid   in   1       input element valid
//  in_ready   out  1       engine accepts element
//  in_data    in   DATA_W  x[k], k implied by beat count
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_data   out  DATA_W  y[out_idx]
//  out_idx    out  OW      index j of out_data
//  out_last   out  1       out_idx == OUT_SIZE-1
//  busy       out  1       vector in flight (k!=0 or state!=ACCUM)
// BEHAVIOUR
//  Reset: state=ACCUM, k=0, acc[*]=0, W/b regs=0, in_ready=1 (first cycle after), out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
//  Reset mid-operation discards partial sums and undrained results; no output emitted for that vector.
//  FSM ACCUM -> BIAS -> DRAIN -> ACCUM.
//  ACCUM: in_ready=1. Beat (in_valid&in_ready): acc[j] += in_data*W[k][j] (signed, full ACC_W) for all j; k++.
//    Beat with k==IN_SIZE-1: k<=0, -> BIAS.
//  BIAS (1 cycle, in_ready=0): r = (acc[j] >>> FRAC_W) + b[j] (floor rounding); saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
//    if cfg_relu (sampled this cycle) and r<0 then r=0; store res[j]; acc[*]<=0; out_idx<=0; -> DRAIN.
//  DRAIN: out_valid=1, out_data=res[out_idx]; data/idx stable while out_ready=0. Handshake: out_idx++;
//    handshake with out_last=1 -> ACCUM next cycle (out_valid=0, in_ready=1).
//  Latency: last input beat at cycle t -> out_valid at t+2; back-to-back vectors: OUT_SIZE+1 cycles min gap.
//  W/b writes: honoured only when busy=0, take effect next cycle; a same-cycle input beat at k==0 uses pre-write W. Writes with busy=1 ignored.
//  Out-of-range w_row/w_col/b_idx writes ignored. Simultaneous w_we and b_we both honoured.
// STRUCTURE
//  Package fc_pkg: fc_state_e {ACCUM,BIAS,DRAIN}; function sat_to(val, DATA_W); width helper functions.
//  Sub-module fc_mac_lane (one per output j, generate loop): holds acc[j], clear/accumulate/realign+bias+sat+relu.
//  Top: FSM, k counter, W/b register files, output mux/drain counter.
// TESTING (DATA_W=16, FRAC_W=8, IN=3, OUT=2; 1.0=256)
//  1 W=[[256,0],[0,256],[0,0]], b=0, x=[512,768,1280] -> out [512,768], out_last on idx1, out_valid 2 cycles after 3rd beat.
//  2 W all 256, b=[-2560,128], x=[256,256,256], relu=0 -> [-1792,896]; relu=1 -> [0,896]; x=[-1,0,0],W[0][0]=256,b=0 -> y0=-1 (floor).
//  3 W all 32512, x all 25600 -> [32767,32767]; x all -25600 -> [-32768,-32768].
//  4 out_ready=0 for 5 cycles in DRAIN -> out_valid=1, out_data/out_idx unchanged, in_ready=0; release -> resumes, no loss/dup.
//  5 rst after 2 beats -> busy=0, no output; reload W of test 1, new vector -> [512,768]; W writes while busy=1 -> ignored.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected stream engine.
//   fc_state_e : engine phase (accumulate inputs, apply bias, drain results)
//   idx_width  : index width for a table of n entries, never below 1 bit
//   acc_width  : accumulator width that cannot overflow for n signed products
//   sat_to     : clamp a wide signed value into a data_w-bit signed range
package fc_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        BIAS,
        DRAIN
    } fc_state_e;

    // Working width for saturation. It is wide enough for any accumulator
    // plus bias that a realistic DATA_W/IN_SIZE combination produces.
    localparam int SAT_W = 128;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int data_w, input int in_size);
        return 2 * data_w + $clog2(in_size) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_to(
        input logic signed [SAT_W-1:0] val,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output lane of the fully-connected engine: owns the running sum for
// output j and the finished result for that output.
//   clk, rst  : clock, synchronous active-high reset
//   accum_en  : add x*w into the running sum this cycle
//   finalize  : realign + bias + saturate (+ optional ReLU) into res, clear sum
//   relu      : clamp a negative finished result to zero
//   x, w      : input element and its weight for this lane
//   bias      : bias for this lane
//   res       : finished result, held until the next finalize
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accum_en,
    input  logic                     finalize,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] res
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SAT_W-1:0]    biased;
    logic signed [DATA_W-1:0]   sat_res;
    logic signed [DATA_W-1:0]   res_next;

    // Operands are sign-extended before the multiply so the full product is kept.
    assign prod = (2 * DATA_W)'(x) * (2 * DATA_W)'(w);

    // Arithmetic shift gives floor rounding on the realigned sum.
    assign biased   = SAT_W'(acc_q >>> FRAC_W) + SAT_W'(bias);
    assign sat_res  = DATA_W'(sat_to(biased, DATA_W));
    assign res_next = (relu && sat_res[DATA_W-1]) ? '0 : sat_res;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            res   <= '0;
        end else if (finalize) begin
            res   <= res_next;
            acc_q <= '0;
        end else if (accum_en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fc_stream_engine.sv
// Sequential fully-connected layer: y[j] = sat((sum_k x[k]*W[k][j]) >>> FRAC_W + b[j]),
// optional ReLU. Input elements stream in one per beat, all outputs accumulate
// in parallel lanes, then results drain one per beat.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_relu          : clamp negative results to zero (sampled in the bias cycle)
//   w_we/w_row/w_col/w_data : weight write port, honoured only while idle
//   b_we/b_idx/b_data : bias write port, honoured only while idle
//   in_valid/in_ready/in_data : input element stream, element index implied
//   out_valid/out_ready/out_data/out_idx/out_last : result stream
//   busy              : a vector is partially accumulated or not yet drained
module fc_stream_engine
    import fc_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int FRAC_W   = 8,
    parameter  int IN_SIZE  = 3,
    parameter  int OUT_SIZE = 2,
    localparam int ACC_W    = acc_width(DATA_W, IN_SIZE),
    localparam int IW       = idx_width(IN_SIZE),
    localparam int OW       = idx_width(OUT_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_relu,
    input  logic                     w_we,
    input  logic [IW-1:0]            w_row,
    input  logic [OW-1:0]            w_col,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     b_we,
    input  logic [OW-1:0]            b_idx,
    input  logic signed [DATA_W-1:0] b_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [OW-1:0]            out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [IW-1:0] K_LAST  = IW'(IN_SIZE - 1);
    localparam logic [OW-1:0] O_LAST  = OW'(OUT_SIZE - 1);
    // One extra bit so an index field that can encode values >= the table
    // size is compared without wrap-around.
    localparam logic [IW:0]   IN_LIM  = (IW + 1)'(IN_SIZE);
    localparam logic [OW:0]   OUT_LIM = (OW + 1)'(OUT_SIZE);

    fc_state_e state_q, state_d;
    logic [IW-1:0] k_q;
    logic [OW-1:0] out_idx_q;

    logic signed [DATA_W-1:0] w_q [IN_SIZE][OUT_SIZE];
    logic signed [DATA_W-1:0] b_q [OUT_SIZE];
    logic signed [DATA_W-1:0] res [OUT_SIZE];

    logic beat;
    logic drain_hs;
    logic finalize;
    logic w_ok;
    logic b_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (k_q == K_LAST)) begin
                    state_d = BIAS;
                end
            end
            BIAS: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (out_idx_q == O_LAST)) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign beat     = in_valid && in_ready;
    assign drain_hs = out_valid && out_ready;
    assign finalize = (state_q == BIAS);
    assign busy     = (k_q != '0) || (state_q != ACCUM);

    // ------------------------------------------------------------------
    // Input element counter and drain counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else if (beat) begin
            k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx_q <= '0;
        end else if (finalize) begin
            out_idx_q <= '0;
        end else if (drain_hs) begin
            out_idx_q <= (out_idx_q == O_LAST) ? '0 : out_idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Weight / bias register files
    // ------------------------------------------------------------------
    assign w_ok = w_we && !busy && ({1'b0, w_row} < IN_LIM) && ({1'b0, w_col} < OUT_LIM);
    assign b_ok = b_we && !busy && ({1'b0, b_idx} < OUT_LIM);

    // NOTE: these are flop-based register files, not RAM macros, so they are
    // reset; an engine used before configuration then computes from zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < IN_SIZE; k++) begin
                for (int j = 0; j < OUT_SIZE; j++) begin
                    w_q[k][j] <= '0;
                end
            end
            for (int j = 0; j < OUT_SIZE; j++) begin
                b_q[j] <= '0;
            end
        end else begin
            if (w_ok) begin
                w_q[w_row][w_col] <= w_data;
            end
            if (b_ok) begin
                b_q[b_idx] <= b_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC lanes, one per output
    // ------------------------------------------------------------------
    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
        fc_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .accum_en (beat),
            .finalize (finalize),
            .relu     (cfg_relu),
            .x        (in_data),
            .w        (w_q[k_q][j]),
            .bias     (b_q[j]),
            .res      (res[j])
        );
    end

    // ------------------------------------------------------------------
    // Result stream
    // ------------------------------------------------------------------
    assign out_idx  = out_idx_q;
    assign out_data = out_valid ? res[out_idx_q] : '0;
    assign out_last = out_valid && (out_idx_q == O_LAST);

endmodule

// File: tb/tb_fc_stream_engine.sv
// Directed bench for fc_stream_engine (DATA_W=16, FRAC_W=8, IN=3, OUT=2).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
module tb_fc_stream_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_relu;
    logic               w_we;
    logic [1:0]         w_row;
    logic [0:0]         w_col;
    logic signed [15:0] w_data;
    logic               b_we;
    logic [0:0]         b_idx;
    logic signed [15:0] b_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [0:0]         out_idx;
    logic               out_last;
    logic               busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fc_stream_engine #(
        .DATA_W   (16),
        .FRAC_W   (8),
        .IN_SIZE  (3),
        .OUT_SIZE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_relu  (cfg_relu),
        .w_we      (w_we),
        .w_row     (w_row),
        .w_col     (w_col),
        .w_data    (w_data),
        .b_we      (b_we),
        .b_idx     (b_idx),
        .b_data    (b_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int k, input int j, input int d);
        w_we   = 1'b1;
        w_row  = 2'(k);
        w_col  = 1'(j);
        w_data = 16'(d);
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    task automatic write_b(input int j, input int d);
        b_we   = 1'b1;
        b_idx  = 1'(j);
        b_data = 16'(d);
        @(negedge clk);
        b_we   = 1'b0;
    endtask

    // Loads all six weights; the two biases go in alongside the first two
    // weight writes so simultaneous weight and bias writes are exercised.
    task automatic load_wb(input int w00, input int w01, input int w10,
                           input int w11, input int w20, input int w21,
                           input int b0, input int b1);
        int wv[6];
        wv = '{w00, w01, w10, w11, w20, w21};
        for (int i = 0; i < 6; i++) begin
            w_we   = 1'b1;
            w_row  = 2'(i / 2);
            w_col  = 1'(i % 2);
            w_data = 16'(wv[i]);
            b_we   = (i < 2);
            b_idx  = 1'(i);
            b_data = (i == 0) ? 16'(b0) : 16'(b1);
            @(negedge clk);
        end
        w_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic send_vec(input int x0, input int x1, input int x2);
        int xs[3];
        xs = '{x0, x1, x2};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(xs[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, out_valid, 1);
    endtask

    task automatic expect_vec(input string tag, input int y0, input int y1);
        out_ready = 1'b1;
        wait_valid(tag);
        check({tag, "_idx0"},  out_idx,  0);
        check({tag, "_y0"},    out_data, y0);
        check({tag, "_last0"}, out_last, 0);
        @(negedge clk);
        check({tag, "_idx1"},  out_idx,  1);
        check({tag, "_y1"},    out_data, y1);
        check({tag, "_last1"}, out_last, 1);
        @(negedge clk);
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready,  1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cfg_relu  = 1'b0;
        w_we      = 1'b0;
        w_row     = '0;
        w_col     = '0;
        w_data    = '0;
        b_we      = 1'b0;
        b_idx     = '0;
        b_data    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_last",  out_last,  0);
        check("rst_busy",      busy,      0);

        // Test 1: identity-like weights and exact latency
        load_wb(256, 0, 0, 256, 0, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'sd512;
        @(negedge clk);
        check("t1_busy_mid", busy, 1);
        in_data  = 16'sd768;
        @(negedge clk);
        in_data  = 16'sd1280;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_bias_valid", out_valid, 0);
        check("t1_bias_ready", in_ready,  0);
        check("t1_bias_busy",  busy,      1);
        @(negedge clk);
        check("t1_latency_valid", out_valid, 1);
        expect_vec("t1", 512, 768);

        // Test 2: bias, ReLU, floor rounding
        load_wb(256, 256, 256, 256, 256, 256, -2560, 128);
        send_vec(256, 256, 256);
        expect_vec("t2_norelu", -1792, 896);
        cfg_relu = 1'b1;
        send_vec(256, 256, 256);
        expect_vec("t2_relu", 0, 896);
        cfg_relu = 1'b0;
        write_b(0, 0);
        write_b(1, 0);
        send_vec(-1, 0, 0);
        expect_vec("t2_floor", -1, -1);

        // Test 3: saturation at both rails
        load_wb(32512, 32512, 32512, 32512, 32512, 32512, 0, 0);
        send_vec(25600, 25600, 25600);
        expect_vec("t3_pos", 32767, 32767);
        send_vec(-25600, -25600, -25600);
        expect_vec("t3_neg", -32768, -32768);

        // Test 4: downstream stall holds the result stream
        load_wb(256, 0, 0, 256, 0, 0, 0, 0);
        write_w(3, 0, 5000);
        out_ready = 1'b0;
        send_vec(512, 768, 1280);
        wait_valid("t4_stall");
        for (int c = 0; c < 5; c++) begin
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_idx",   out_idx,   0);
            check("t4_stall_data",  out_data,  512);
            check("t4_stall_ready", in_ready,  0);
            @(negedge clk);
        end
        expect_vec("t4_release", 512, 768);

        // Test 5: reset mid-vector discards everything, including W/b
        send_vec(512, 768, 1280);
        expect_vec("t5_pre", 512, 768);
        in_valid = 1'b1;
        in_data  = 16'sd512;
        @(negedge clk);
        in_data  = 16'sd768;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_busy",  busy,      0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready,  1);
        repeat (4) @(negedge clk);
        check("t5_no_output", out_valid, 0);
        send_vec(512, 768, 1280);
        expect_vec("t5_cleared_w", 0, 0);
        load_wb(256, 0, 0, 256, 0, 0, 0, 0);
        send_vec(512, 768, 1280);
        expect_vec("t5_reload", 512, 768);

        // Writes while busy (mid-vector and in the bias cycle) are ignored
        in_valid = 1'b1;
        in_data  = 16'sd512;
        @(negedge clk);
        in_valid = 1'b0;
        write_w(0, 0, 0);
        write_b(0, 77);
        in_valid = 1'b1;
        in_data  = 16'sd768;
        @(negedge clk);
        in_data  = 16'sd1280;
        @(negedge clk);
        in_valid = 1'b0;
        write_w(1, 1, 0);
        expect_vec("t5_busy_wr", 512, 768);
        send_vec(512, 768, 1280);
        expect_vec("t5_busy_wr_after", 512, 768);

        // A write in the same cycle as the k==0 beat uses the old weight
        in_valid = 1'b1;
        in_data  = 16'sd512;
        w_we     = 1'b1;
        w_row    = 2'd0;
        w_col    = 1'd0;
        w_data   = 16'sd0;
        @(negedge clk);
        w_we     = 1'b0;
        in_data  = 16'sd768;
        @(negedge clk);
        in_data  = 16'sd1280;
        @(negedge clk);
        in_valid = 1'b0;
        expect_vec("t5_same_cycle", 512, 768);
        send_vec(512, 768, 1280);
        expect_vec("t5_new_w", 0, 768);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
